// File: rtl/cpu_debug_arbiter_pkg.sv
// Shared encodings for the CPU debug arbiter: FSM states, target indices and
// legacy debug-mode codes.
package cpu_debug_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALT    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_OWN     = 3'd3,
        ST_ACCESS  = 3'd4,
        ST_RELEASE = 3'd5
    } dbg_state_e;

    localparam int TGT_ICACHE = 0;
    localparam int TGT_REG    = 1;
    localparam int TGT_DCACHE = 2;

    // Mode codes carried over from the old combinational debug mux.
    localparam logic [1:0] DEBUG_NONE   = 2'b00;
    localparam logic [1:0] DEBUG_ICACHE = 2'b01;
    localparam logic [1:0] DEBUG_REG    = 2'b10;
    localparam logic [1:0] DEBUG_DCACHE = 2'b11;

    // The core keeps the SRAM pins in every state except OWN and ACCESS.
    function automatic logic is_pass_through(input dbg_state_e s);
        return (s != ST_OWN) && (s != ST_ACCESS);
    endfunction

endpackage

// File: rtl/cpu_dbg_watchdog.sv
// Halt-acknowledge watchdog: down-counter that runs while the arbiter waits in
// HALT and flags expiry after LIMIT cycles.
module cpu_dbg_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_LOAD;
        end else if (!run) begin
            cnt <= CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/cpu_debug_arbiter.sv
// Handshaked debug-port arbiter for the icache / regfile / dcache SRAM pins.
// Optional halt watchdog enabled by defining CPU_DBG_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | core owns pins, waiting for dbg_en
//   HALT    | cpu_halt_req raised, waiting for cpu_halted
//   DRAIN   | pipeline drain count, core pins still passed through
//   OWN     | debug port owns pins, ready for a request
//   ACCESS  | one request in flight on the selected target
//   RELEASE | halt and ownership dropped, back to IDLE next cycle
module cpu_debug_arbiter
    import cpu_debug_arbiter_pkg::*;
#(
    parameter int                 NUM_TGT      = 3,
    parameter int                 ADDR_WIDTH   = 32,
    parameter int                 DATA_WIDTH   = 32,
    parameter logic [NUM_TGT-1:0] TGT_WR_MASK  = 3'b101,
    parameter int                 RD_LATENCY   = 1,
    parameter int                 DRAIN_CYCLES = 4,
    parameter int                 HALT_TIMEOUT = 64,
    localparam int                TGT_W        = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            dbg_en,
    output logic                            dbg_own,
    input  logic                            dbg_req_valid,
    output logic                            dbg_req_ready,
    input  logic [TGT_W-1:0]                dbg_req_tgt,
    input  logic                            dbg_req_we,
    input  logic [ADDR_WIDTH-1:0]           dbg_req_addr,
    input  logic [DATA_WIDTH-1:0]           dbg_req_wdata,
    input  logic [DATA_WIDTH-1:0]           dbg_req_bweb,
    output logic                            dbg_rsp_valid,
    output logic                            dbg_rsp_err,
    output logic [DATA_WIDTH-1:0]           dbg_rsp_rdata,
    output logic                            dbg_halt_timeout,

    output logic                            cpu_halt_req,
    input  logic                            cpu_halted,

    input  logic [NUM_TGT-1:0]              int_ceb,
    input  logic [NUM_TGT-1:0]              int_web,
    input  logic [NUM_TGT*ADDR_WIDTH-1:0]   int_addr,
    input  logic [NUM_TGT*DATA_WIDTH-1:0]   int_bweb,
    input  logic [NUM_TGT*DATA_WIDTH-1:0]   int_wdata,

    output logic [NUM_TGT-1:0]              tgt_ceb,
    output logic [NUM_TGT-1:0]              tgt_web,
    output logic [NUM_TGT*ADDR_WIDTH-1:0]   tgt_addr,
    output logic [NUM_TGT*DATA_WIDTH-1:0]   tgt_bweb,
    output logic [NUM_TGT*DATA_WIDTH-1:0]   tgt_wdata,
    input  logic [NUM_TGT*DATA_WIDTH-1:0]   tgt_rdata
);

    localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int LAT_W = $clog2(RD_LATENCY + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYCLES);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY);

    dbg_state_e              state;
    logic [DRN_W-1:0]        drn_cnt;
    logic [LAT_W-1:0]        acc_cnt;

    logic [TGT_W-1:0]        req_tgt;
    logic                    req_we;
    logic                    req_err;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH-1:0]   req_bweb;

    logic                    new_in_range;
    logic                    new_wr_ok;
    logic                    new_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    pass_thru;
    logic                    issue;
    logic                    acc_done;
    logic                    wd_expired;
    logic                    halt_to_q;

    always_comb begin
        new_in_range = 1'b0;
        new_wr_ok    = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (dbg_req_tgt == TGT_W'(i)) begin
                new_in_range = 1'b1;
                new_wr_ok    = TGT_WR_MASK[i];
            end
        end
    end

    assign new_err = !new_in_range || (dbg_req_we && !new_wr_ok);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (req_tgt == TGT_W'(i)) begin
                sel_rdata = tgt_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // acc_cnt is loaded with RD_LATENCY on accept, so the pin cycle is the
    // one where it still equals the load value; reads finish when it hits 0.
    assign pass_thru = is_pass_through(state);
    assign issue     = (state == ST_ACCESS) && (acc_cnt == LAT_LOAD) && !req_err;
    assign acc_done  = req_we || req_err || (acc_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cpu_halt_req  <= 1'b0;
            dbg_own       <= 1'b0;
            dbg_req_ready <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_err   <= 1'b0;
            dbg_rsp_rdata <= '0;
            drn_cnt       <= '0;
            acc_cnt       <= '0;
            req_tgt       <= '0;
            req_we        <= 1'b0;
            req_err       <= 1'b0;
            req_addr      <= '0;
            req_wdata     <= '0;
            req_bweb      <= '1;
        end else begin
            dbg_rsp_valid <= 1'b0;
            dbg_rsp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dbg_en && !halt_to_q) begin
                        state        <= ST_HALT;
                        cpu_halt_req <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (cpu_halted) begin
                        state   <= ST_DRAIN;
                        drn_cnt <= DRN_LOAD;
                    end else if (wd_expired) begin
                        state        <= ST_RELEASE;
                        cpu_halt_req <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt != '0) begin
                        drn_cnt <= drn_cnt - 1'b1;
                    end else if (dbg_en) begin
                        state         <= ST_OWN;
                        dbg_own       <= 1'b1;
                        dbg_req_ready <= 1'b1;
                    end else begin
                        state        <= ST_RELEASE;
                        cpu_halt_req <= 1'b0;
                    end
                end
                ST_OWN: begin
                    if (dbg_req_valid) begin
                        state         <= ST_ACCESS;
                        dbg_req_ready <= 1'b0;
                        acc_cnt       <= LAT_LOAD;
                        req_tgt       <= dbg_req_tgt;
                        req_we        <= dbg_req_we;
                        req_err       <= new_err;
                        req_addr      <= dbg_req_addr;
                        req_wdata     <= dbg_req_wdata;
                        req_bweb      <= dbg_req_bweb;
                    end else if (!dbg_en) begin
                        state         <= ST_RELEASE;
                        dbg_own       <= 1'b0;
                        dbg_req_ready <= 1'b0;
                        cpu_halt_req  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // Always back through OWN so a dropped dbg_en releases there.
                    if (acc_done) begin
                        state         <= ST_OWN;
                        dbg_req_ready <= 1'b1;
                        dbg_rsp_valid <= 1'b1;
                        dbg_rsp_err   <= req_err;
                        if (req_err) begin
                            dbg_rsp_rdata <= '0;
                        end else if (!req_we) begin
                            dbg_rsp_rdata <= sel_rdata;
                        end
                    end else begin
                        acc_cnt <= acc_cnt - 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CPU_DBG_TIMEOUT_EN
    cpu_dbg_watchdog #(
        .LIMIT   (HALT_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state == ST_HALT),
        .expired (wd_expired)
    );

    // Sticky until the debugger lets go of dbg_en, so IDLE cannot re-halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_to_q <= 1'b0;
        end else if ((state == ST_HALT) && !cpu_halted && wd_expired) begin
            halt_to_q <= 1'b1;
        end else if ((state == ST_IDLE) && !dbg_en) begin
            halt_to_q <= 1'b0;
        end
    end
`else
    // Without the watchdog HALT waits forever; the limit never applies.
    assign wd_expired = (HALT_TIMEOUT < 0);
    assign halt_to_q  = 1'b0;
`endif

    assign dbg_halt_timeout = halt_to_q;

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_pin
        logic sel;
        assign sel = issue && (req_tgt == TGT_W'(g));

        assign tgt_ceb[g] = pass_thru ? int_ceb[g] : ~sel;
        assign tgt_web[g] = pass_thru ? int_web[g] : ~(sel & req_we);
        assign tgt_addr[g*ADDR_WIDTH +: ADDR_WIDTH] =
            pass_thru ? int_addr[g*ADDR_WIDTH +: ADDR_WIDTH] : req_addr;
        assign tgt_bweb[g*DATA_WIDTH +: DATA_WIDTH] =
            pass_thru ? int_bweb[g*DATA_WIDTH +: DATA_WIDTH] : req_bweb;
        assign tgt_wdata[g*DATA_WIDTH +: DATA_WIDTH] =
            pass_thru ? int_wdata[g*DATA_WIDTH +: DATA_WIDTH] : req_wdata;
    end

endmodule

// File: tb/tb_cpu_debug_arbiter.sv
// Directed bench for cpu_debug_arbiter with a 1-cycle-latency SRAM model on
// each target; the timeout section runs only when CPU_DBG_TIMEOUT_EN is set.
module tb_cpu_debug_arbiter;

    localparam int NT = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DRAIN_CYCLES = 4;
    localparam int HALT_TIMEOUT = 64;

    logic              clk;
    logic              rst_n;
    logic              dbg_en;
    logic              dbg_own;
    logic              dbg_req_valid;
    logic              dbg_req_ready;
    logic [1:0]        dbg_req_tgt;
    logic              dbg_req_we;
    logic [AW-1:0]     dbg_req_addr;
    logic [DW-1:0]     dbg_req_wdata;
    logic [DW-1:0]     dbg_req_bweb;
    logic              dbg_rsp_valid;
    logic              dbg_rsp_err;
    logic [DW-1:0]     dbg_rsp_rdata;
    logic              dbg_halt_timeout;
    logic              cpu_halt_req;
    logic              cpu_halted;
    logic [NT-1:0]     int_ceb;
    logic [NT-1:0]     int_web;
    logic [NT*AW-1:0]  int_addr;
    logic [NT*DW-1:0]  int_bweb;
    logic [NT*DW-1:0]  int_wdata;
    logic [NT-1:0]     tgt_ceb;
    logic [NT-1:0]     tgt_web;
    logic [NT*AW-1:0]  tgt_addr;
    logic [NT*DW-1:0]  tgt_bweb;
    logic [NT*DW-1:0]  tgt_wdata;
    logic [NT*DW-1:0]  tgt_rdata;

    logic [DW-1:0]     rdata_q [NT];
    logic [DW-1:0]     last_wr_data [NT];
    logic [AW-1:0]     last_wr_addr [NT];
    int                ceb_cnt [NT];

    int n_checks = 0;
    int n_fail   = 0;

    cpu_debug_arbiter #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dbg_en           (dbg_en),
        .dbg_own          (dbg_own),
        .dbg_req_valid    (dbg_req_valid),
        .dbg_req_ready    (dbg_req_ready),
        .dbg_req_tgt      (dbg_req_tgt),
        .dbg_req_we       (dbg_req_we),
        .dbg_req_addr     (dbg_req_addr),
        .dbg_req_wdata    (dbg_req_wdata),
        .dbg_req_bweb     (dbg_req_bweb),
        .dbg_rsp_valid    (dbg_rsp_valid),
        .dbg_rsp_err      (dbg_rsp_err),
        .dbg_rsp_rdata    (dbg_rsp_rdata),
        .dbg_halt_timeout (dbg_halt_timeout),
        .cpu_halt_req     (cpu_halt_req),
        .cpu_halted       (cpu_halted),
        .int_ceb          (int_ceb),
        .int_web          (int_web),
        .int_addr         (int_addr),
        .int_bweb         (int_bweb),
        .int_wdata        (int_wdata),
        .tgt_ceb          (tgt_ceb),
        .tgt_web          (tgt_web),
        .tgt_addr         (tgt_addr),
        .tgt_bweb         (tgt_bweb),
        .tgt_wdata        (tgt_wdata),
        .tgt_rdata        (tgt_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read pattern is a fixed function of target and address.
    always @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (!tgt_ceb[i]) begin
                ceb_cnt[i] <= ceb_cnt[i] + 1;
                if (!tgt_web[i]) begin
                    last_wr_addr[i] <= tgt_addr[i*AW +: AW];
                    last_wr_data[i] <= tgt_wdata[i*DW +: DW] & ~tgt_bweb[i*DW +: DW];
                end else if (i == 2 && tgt_addr[i*AW +: AW] == 32'h10) begin
                    rdata_q[i] <= 32'hDEADBEEF;
                end else begin
                    rdata_q[i] <= 32'hA5000000 | (32'(i) << 16) | {16'h0, tgt_addr[i*AW +: 16]};
                end
            end
        end
    end

    assign tgt_rdata = {rdata_q[2], rdata_q[1], rdata_q[0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lat counts clock edges after the accept edge until rsp_valid is seen.
    task automatic do_req(input logic [1:0] tgt, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] bweb, input logic drop_en,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int p0, output int p1, output int p2);
        int c0, c1, c2;
        c0 = ceb_cnt[0];
        c1 = ceb_cnt[1];
        c2 = ceb_cnt[2];
        check("req_ready_before", dbg_req_ready, 1'b1);
        dbg_req_valid = 1'b1;
        dbg_req_tgt   = tgt;
        dbg_req_we    = we;
        dbg_req_addr  = addr;
        dbg_req_wdata = wdata;
        dbg_req_bweb  = bweb;
        tick();
        dbg_req_valid = 1'b0;
        if (drop_en) dbg_en = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (dbg_rsp_valid) begin
                lat = k;
                break;
            end
        end
        err   = dbg_rsp_err;
        rdata = dbg_rsp_rdata;
        p0 = ceb_cnt[0] - c0;
        p1 = ceb_cnt[1] - c1;
        p2 = ceb_cnt[2] - c2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    initial begin
        int lat, p0, p1, p2, n;
        logic err;
        logic [31:0] rd;

        for (int i = 0; i < NT; i++) begin
            ceb_cnt[i]      = 0;
            rdata_q[i]      = '0;
            last_wr_data[i] = '0;
            last_wr_addr[i] = '0;
        end
        rst_n         = 1'b0;
        dbg_en        = 1'b0;
        cpu_halted    = 1'b0;
        dbg_req_valid = 1'b0;
        dbg_req_tgt   = '0;
        dbg_req_we    = 1'b0;
        dbg_req_addr  = '0;
        dbg_req_wdata = '0;
        dbg_req_bweb  = '0;
        int_ceb       = 3'b110;
        int_web       = 3'b111;
        int_addr      = '0;
        int_addr[31:0] = 32'h40;
        int_bweb      = '0;
        int_wdata     = '0;
        #2;
        check("rst_halt_req", cpu_halt_req, 1'b0);
        check("rst_own", dbg_own, 1'b0);
        check("rst_ready", dbg_req_ready, 1'b0);
        check("rst_rsp_valid", dbg_rsp_valid, 1'b0);
        check("rst_rsp_err", dbg_rsp_err, 1'b0);
        check("rst_rsp_rdata", dbg_rsp_rdata, 32'h0);
        check("rst_timeout", dbg_halt_timeout, 1'b0);
        check("rst_tgt_ceb", tgt_ceb, 3'b110);
        check("rst_tgt_addr0", tgt_addr[31:0], 32'h40);

        #20 rst_n = 1'b1;
        tick();
        tick();

        // Pass-through in IDLE is combinational: no clock edge in between.
        int_ceb         = 3'b101;
        int_addr[63:32] = 32'h44;
        int_web         = 3'b011;
        #1;
        check("idle_tgt_ceb", tgt_ceb, 3'b101);
        check("idle_tgt_web", tgt_web, 3'b011);
        check("idle_tgt_addr1", tgt_addr[63:32], 32'h44);
        check("idle_tgt_addr0", tgt_addr[31:0], 32'h40);
        check("idle_halt_req", cpu_halt_req, 1'b0);
        int_ceb = 3'b111;
        int_web = 3'b111;

        dbg_en = 1'b1;
        tick();
        check("halt_req_up", cpu_halt_req, 1'b1);
        check("halt_own", dbg_own, 1'b0);
        tick();
        tick();
        // First edge seeing halted enters DRAIN; DRAIN_CYCLES+1 further edges reach OWN.
        cpu_halted = 1'b1;
        n = 0;
        while (!dbg_own && n < 20) begin
            tick();
            n++;
        end
        check("own_rise_edges", n, DRAIN_CYCLES + 2);
        check("own_ready", dbg_req_ready, 1'b1);
        check("own_halt_req", cpu_halt_req, 1'b1);
        int_ceb = 3'b000;
        int_web = 3'b000;
        #1;
        check("own_ceb_held", tgt_ceb, 3'b111);
        check("own_web_held", tgt_web, 3'b111);
        int_ceb = 3'b111;
        int_web = 3'b111;

        do_req(2'd2, 1'b0, 32'h10, 32'h0, 32'hFFFFFFFF, 1'b0, lat, err, rd, p0, p1, p2);
        check("rd2_lat", lat, 2);
        check("rd2_err", err, 1'b0);
        check("rd2_rdata", rd, 32'hDEADBEEF);
        check("rd2_ceb_pulses", p2, 1);
        check("rd2_other_pulses", p0 + p1, 0);
        check("rd2_ready_back", dbg_req_ready, 1'b1);
        tick();
        tick();
        check("rdata_hold", dbg_rsp_rdata, 32'hDEADBEEF);
        check("rsp_valid_pulse", dbg_rsp_valid, 1'b0);

        do_req(2'd1, 1'b0, 32'h4, 32'h0, 32'hFFFFFFFF, 1'b0, lat, err, rd, p0, p1, p2);
        check("rd1_lat", lat, 2);
        check("rd1_rdata", rd, 32'hA5010004);
        check("rd1_ceb_pulses", p1, 1);

        do_req(2'd1, 1'b1, 32'h4, 32'h1234, 32'h0, 1'b0, lat, err, rd, p0, p1, p2);
        check("wr1_ro_lat", lat, 1);
        check("wr1_ro_err", err, 1'b1);
        check("wr1_ro_rdata", rd, 32'h0);
        check("wr1_ro_pulses", p0 + p1 + p2, 0);

        do_req(2'd3, 1'b1, 32'h4, 32'h1234, 32'h0, 1'b0, lat, err, rd, p0, p1, p2);
        check("wr3_lat", lat, 1);
        check("wr3_err", err, 1'b1);
        check("wr3_pulses", p0 + p1 + p2, 0);

        do_req(2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, lat, err, rd, p0, p1, p2);
        check("rd3_lat", lat, 1);
        check("rd3_err", err, 1'b1);

        // Upper half enabled only (bweb active-low), dbg_en dropped while in ACCESS.
        do_req(2'd0, 1'b1, 32'h8, 32'hCAFEF00D, 32'h0000FFFF, 1'b1, lat, err, rd, p0, p1, p2);
        check("wr0_lat", lat, 1);
        check("wr0_err", err, 1'b0);
        check("wr0_pulses", p0, 1);
        check("wr0_addr", last_wr_addr[0], 32'h8);
        check("wr0_data", last_wr_data[0], 32'hCAFE0000);
        check("wr0_halt_req_at_rsp", cpu_halt_req, 1'b1);
        tick();
        check("rel_halt_req", cpu_halt_req, 1'b0);
        check("rel_own", dbg_own, 1'b0);
        tick();
        int_ceb = 3'b011;
        #1;
        check("rel_idle_ceb", tgt_ceb, 3'b011);
        check("rel_idle_ready", dbg_req_ready, 1'b0);
        int_ceb = 3'b111;

        // Reset in the middle of a read: nothing answered, everything cleared.
        dbg_en = 1'b1;
        n = 0;
        while (!dbg_own && n < 30) begin
            tick();
            n++;
        end
        check("reown", dbg_own, 1'b1);
        dbg_req_valid = 1'b1;
        dbg_req_tgt   = 2'd2;
        dbg_req_we    = 1'b0;
        dbg_req_addr  = 32'h10;
        tick();
        dbg_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_own", dbg_own, 1'b0);
        check("abort_halt_req", cpu_halt_req, 1'b0);
        check("abort_rdata", dbg_rsp_rdata, 32'h0);
        tick();
        tick();
        check("abort_no_rsp", dbg_rsp_valid, 1'b0);
        check("abort_ceb", tgt_ceb, 3'b111);
        dbg_en = 1'b0;
        rst_n  = 1'b1;
        tick();

`ifdef CPU_DBG_TIMEOUT_EN
        cpu_halted = 1'b0;
        dbg_en = 1'b1;
        tick();
        check("to_halt_req_up", cpu_halt_req, 1'b1);
        n = 0;
        while (cpu_halt_req && n < 200) begin
            tick();
            n++;
        end
        check("to_edges", n, HALT_TIMEOUT);
        check("to_flag", dbg_halt_timeout, 1'b1);
        tick();
        tick();
        check("to_no_rehalt", cpu_halt_req, 1'b0);
        check("to_flag_sticky", dbg_halt_timeout, 1'b1);
        rst_n = 1'b0;
        #1;
        check("to_rst_clear", dbg_halt_timeout, 1'b0);
        dbg_en = 1'b0;
        rst_n  = 1'b1;
        tick();
`else
        check("no_to_flag", dbg_halt_timeout, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
